// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard beside the ID stage.
// Counts register writers in flight between issue (ID->EXE) and WB retire,
// plus loads whose data is not yet forwardable, and derives the issue stall.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   issue_valid/wen/waddr  instruction offered by ID and its destination
//   issue_load, issue_src  load flag and packed source addresses (NSRC x AW)
//   issue_ready            combinational issue permission
//   src_busy, src_ld_busy  per-source pending-write / pending-load status
//   ld_done, ld_done_addr  load data became forwardable in MEM
//   retire_we, retire_addr WB register-file write
//   flush                  discard all in-flight tracking
//   busy_any, err          any write pending / sticky protocol error
module reg_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned NSRC   = 2,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned FWD_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic               issue_wen,
  input  logic [AW-1:0]      issue_waddr,
  input  logic               issue_load,
  input  logic [NSRC*AW-1:0] issue_src,
  output logic               issue_ready,
  output logic [NSRC-1:0]    src_busy,
  output logic [NSRC-1:0]    src_ld_busy,
  input  logic               ld_done,
  input  logic [AW-1:0]      ld_done_addr,
  input  logic               retire_we,
  input  logic [AW-1:0]      retire_addr,
  input  logic               flush,
  output logic               busy_any,
  output logic               err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] wcnt_q [NREG];
  logic [CNT_W-1:0] wcnt_d [NREG];
  logic [CNT_W-1:0] lcnt_q [NREG];
  logic [CNT_W-1:0] lcnt_d [NREG];
  logic             err_q;
  logic             err_d;
  logic [NSRC-1:0]  src_hazard;
  logic [CNT_W-1:0] dst_wcnt;
  logic             dst_sat;
  logic             fire;

  // A decrement on an empty counter is dropped; inc+dec in one cycle nets out.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic inc,
                                                 input logic dec);
    logic dec_ok;
    dec_ok = dec & (cnt != '0);
    case ({inc, dec_ok})
      2'b10:   next_cnt = cnt + CNT_ONE;
      2'b01:   next_cnt = cnt - CNT_ONE;
      default: next_cnt = cnt;
    endcase
  endfunction

  // Source lookup; register 0 never matches so it always reads as idle.
  always_comb begin
    src_busy    = '0;
    src_ld_busy = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      for (int r = 1; r < int'(NREG); r++) begin
        if (issue_src[i*AW +: AW] == AW'(r)) begin
          src_busy[i]    = (wcnt_q[r] != '0);
          src_ld_busy[i] = (lcnt_q[r] != '0);
        end
      end
    end
  end

  // With forwarding only an unforwardable load blocks a reader.
  assign src_hazard = (FWD_EN != 0) ? src_ld_busy : src_busy;

  // Destination counter lookup for the saturation stall.
  always_comb begin
    dst_wcnt = '0;
    for (int r = 1; r < int'(NREG); r++) begin
      if (issue_waddr == AW'(r)) dst_wcnt = wcnt_q[r];
    end
  end

  assign dst_sat     = issue_wen & (issue_waddr != '0) & (dst_wcnt == CNT_MAX);
  assign issue_ready = ~flush & ~(|src_hazard) & ~dst_sat;
  assign fire        = issue_valid & issue_ready;

  // Counter next state; flush zeroes everything and leaves err alone.
  always_comb begin
    err_d = err_q;
    for (int r = 0; r < int'(NREG); r++) begin
      wcnt_d[r] = '0;
      lcnt_d[r] = '0;
    end
    if (!flush) begin
      for (int r = 1; r < int'(NREG); r++) begin
        wcnt_d[r] = next_cnt(wcnt_q[r],
                             fire & issue_wen & (issue_waddr == AW'(r)),
                             retire_we & (retire_addr == AW'(r)));
        lcnt_d[r] = next_cnt(lcnt_q[r],
                             fire & issue_wen & issue_load & (issue_waddr == AW'(r)),
                             ld_done & (ld_done_addr == AW'(r)));
        if (retire_we && (retire_addr == AW'(r)) && (wcnt_q[r] == '0)) err_d = 1'b1;
        if (ld_done && (ld_done_addr == AW'(r)) && (lcnt_q[r] == '0)) err_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREG); r++) begin
        wcnt_q[r] <= '0;
        lcnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      lcnt_q <= lcnt_d;
      err_q  <= err_d;
    end
  end

  // Any pending writer anywhere.
  always_comb begin
    busy_any = 1'b0;
    for (int r = 1; r < int'(NREG); r++) begin
      busy_any = busy_any | (wcnt_q[r] != '0);
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: one instance per forwarding mode, shared stimulus,
// reference model kept as a list of in-flight writer instructions.
module tb_reg_scoreboard;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               issue_valid, issue_wen, issue_load;
  logic [AW-1:0]      issue_waddr;
  logic [NSRC*AW-1:0] issue_src;
  logic               ld_done, retire_we, flush;
  logic [AW-1:0]      ld_done_addr, retire_addr;

  logic            rdy0, ba0, err0, rdy1, ba1, err1;
  logic [NSRC-1:0] sb0, slb0, sb1, slb1;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .CNT_W(CNT_W), .FWD_EN(0)) u_nofwd (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .issue_load(issue_load), .issue_src(issue_src),
    .issue_ready(rdy0), .src_busy(sb0), .src_ld_busy(slb0), .ld_done(ld_done),
    .ld_done_addr(ld_done_addr), .retire_we(retire_we), .retire_addr(retire_addr),
    .flush(flush), .busy_any(ba0), .err(err0));

  reg_scoreboard #(.NREG(NREG), .AW(AW), .NSRC(NSRC), .CNT_W(CNT_W), .FWD_EN(1)) u_fwd (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_waddr(issue_waddr), .issue_load(issue_load), .issue_src(issue_src),
    .issue_ready(rdy1), .src_busy(sb1), .src_ld_busy(slb1), .ld_done(ld_done),
    .ld_done_addr(ld_done_addr), .retire_we(retire_we), .retire_addr(retire_addr),
    .flush(flush), .busy_any(ba1), .err(err1));

  typedef struct {
    int addr;
    bit load;
    bit done;
  } ent_t;

  typedef struct {
    bit       rdy;
    bit [1:0] sb;
    bit [1:0] slb;
    bit       ba;
    bit       er;
    string    tag;
  } exp_t;

  ent_t infl[$];
  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   sel    = 0;
  bit   err_m  = 1'b0;

  // Writers in flight to register a.
  function automatic int pend(int a);
    int n = 0;
    if (a == 0) return 0;
    foreach (infl[k]) if (infl[k].addr == a) n++;
    return n;
  endfunction

  // Loads in flight to a whose data is not yet forwardable.
  function automatic int ldpend(int a);
    int n = 0;
    if (a == 0) return 0;
    foreach (infl[k]) if (infl[k].addr == a && infl[k].load && !infl[k].done) n++;
    return n;
  endfunction

  function automatic bit hazard(int a);
    if (sel == 1) return ldpend(a) > 0;
    return pend(a) > 0;
  endfunction

  function automatic void chk(string name, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endfunction

  // Monitor: one expectation per cycle, compared mid-cycle.
  exp_t mon_e;
  logic m_rdy, m_ba, m_er;
  logic [1:0] m_sb, m_slb;
  always @(negedge clk) begin
    if (expq.size() != 0) begin
      mon_e = expq.pop_front();
      if (sel == 0) begin
        m_rdy = rdy0; m_sb = sb0; m_slb = slb0; m_ba = ba0; m_er = err0;
      end else begin
        m_rdy = rdy1; m_sb = sb1; m_slb = slb1; m_ba = ba1; m_er = err1;
      end
      chk({mon_e.tag, ":issue_ready"}, int'(m_rdy), int'(mon_e.rdy));
      chk({mon_e.tag, ":src_busy"}, int'(m_sb), int'(mon_e.sb));
      chk({mon_e.tag, ":src_ld_busy"}, int'(m_slb), int'(mon_e.slb));
      chk({mon_e.tag, ":busy_any"}, int'(m_ba), int'(mon_e.ba));
      chk({mon_e.tag, ":err"}, int'(m_er), int'(mon_e.er));
    end
  end

  // One cycle: drive inputs, predict outputs, then advance the model at the edge.
  task automatic step(input bit v, input bit wen, input int wa, input bit ld,
                      input int s0, input int s1, input bit ldd, input int lda,
                      input bit rw, input int ra, input bit fl, input string tag);
    exp_t e;
    int   pr, pl, idx;
    issue_valid  = v;
    issue_wen    = wen;
    issue_waddr  = AW'(wa);
    issue_load   = ld;
    issue_src    = {AW'(s1), AW'(s0)};
    ld_done      = ldd;
    ld_done_addr = AW'(lda);
    retire_we    = rw;
    retire_addr  = AW'(ra);
    flush        = fl;
    if (reset) begin
      infl.delete();
      err_m = 1'b0;
    end
    e.sb  = {pend(s1) > 0, pend(s0) > 0};
    e.slb = {ldpend(s1) > 0, ldpend(s0) > 0};
    e.rdy = !fl && !hazard(s0) && !hazard(s1) && !(wen && wa != 0 && pend(wa) >= CMAX);
    e.ba  = infl.size() > 0;
    e.er  = err_m;
    e.tag = tag;
    expq.push_back(e);
    @(posedge clk);
    if (!reset) begin
      if (fl) begin
        infl.delete();
      end else begin
        pr = pend(ra);
        pl = ldpend(lda);
        if (rw && ra != 0) begin
          if (pr == 0) err_m = 1'b1;
          else begin
            idx = -1;
            foreach (infl[k])
              if (idx < 0 && infl[k].addr == ra && !(infl[k].load && !infl[k].done)) idx = k;
            if (idx < 0) foreach (infl[k]) if (idx < 0 && infl[k].addr == ra) idx = k;
            infl.delete(idx);
          end
        end
        if (ldd && lda != 0) begin
          if (pl == 0) err_m = 1'b1;
          else begin
            idx = -1;
            foreach (infl[k])
              if (idx < 0 && infl[k].addr == lda && infl[k].load && !infl[k].done) idx = k;
            infl[idx].done = 1'b1;
          end
        end
        if (v && e.rdy && wen && wa != 0) infl.push_back('{wa, ld, 1'b0});
      end
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst_flush");
    step(1, 1, 7, 0, 3, 4, 0, 0, 0, 0, 0, "rst_idle");
    reset = 1'b0;
  endtask

  // Pipeline-shaped random traffic: retires in order, loads complete before retire.
  task automatic rand_cycles(input int n, input string tag);
    bit v, wen, ld, ldd, rw, fl;
    int wa, s0, s1, lda, ra, j;
    for (int c = 0; c < n; c++) begin
      fl = ($urandom % 50) == 0;
      rw = 0; ra = 0;
      if (infl.size() > 0 && (!infl[0].load || infl[0].done) && ($urandom % 3) == 0) begin
        rw = 1; ra = infl[0].addr;
      end else if (($urandom % 20) == 0) begin
        rw = 1; ra = 0;
      end
      ldd = 0; lda = 0; j = -1;
      foreach (infl[k]) if (j < 0 && infl[k].load && !infl[k].done) j = k;
      if (j >= 0 && ($urandom % 2) == 0) begin
        ldd = 1; lda = infl[j].addr;
      end else if (($urandom % 20) == 0) begin
        ldd = 1; lda = 0;
      end
      v   = ($urandom % 4) != 0;
      wen = ($urandom % 4) != 0;
      wa  = int'($urandom % 8);
      ld  = ($urandom % 3) == 0;
      s0  = int'($urandom % 8);
      s1  = int'($urandom % 8);
      step(v, wen, wa, ld, s0, s1, ldd, lda, rw, ra, fl, tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    issue_valid = 0; issue_wen = 0; issue_waddr = '0; issue_load = 0; issue_src = '0;
    ld_done = 0; ld_done_addr = '0; retire_we = 0; retire_addr = '0; flush = 0;
    @(posedge clk);
    #1;

    // No forwarding.
    sel = 0;
    do_reset();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "r0_issue");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "r0_read");
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, "raw_issue5");
    step(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, "raw_stall");
    step(1, 0, 0, 0, 5, 0, 0, 0, 1, 5, 0, "raw_retire");
    step(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, "raw_release");
    for (int k = 0; k < 3; k++) step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, "sat_fill");
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, "sat_block");
    step(1, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, "sat_retire");
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, "sat_fire");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 3, 0, 0, 0, 1, 3, 0, "sat_drain");
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, "fl_fill");
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, "fl_fill");
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, "fl_flush");
    step(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, "fl_after");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, "err_retire9");
    idle("err_set");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "err_flush");
    idle("err_kept");
    do_reset();
    idle("err_cleared");
    rand_cycles(1500, "rand_nofwd");

    // Forwarding.
    sel = 1;
    do_reset();
    step(1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0, "ld_issue8");
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, "ld_use_stall");
    step(1, 0, 0, 0, 8, 0, 1, 8, 0, 0, 0, "ld_done8");
    step(1, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, "ld_use_go");
    step(0, 0, 0, 0, 8, 0, 0, 0, 1, 8, 0, "ld_retire8");
    idle("ld_idle");
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, "err_lddone6");
    idle("err_ld_set");
    do_reset();
    rand_cycles(1500, "rand_fwd");

    // Mid-stream reset loses everything.
    reset = 1'b1;
    idle("mid_reset");
    reset = 1'b0;
    idle("post_reset");
    @(negedge clk);
    #1;
    chk("drain", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
